ad9911_spi_ctrl: RTL

Serial configuration controller for one AD9911 DDS (LO or RF channel). It accepts register-write commands over a valid/ready handshake and serialises each one onto the AD9911 3-wire port (CS, SCLK, SDIO0, single-bit MSB-first mode). After a write it can pulse IO_UPDATE, and it drives MASTER_RESET at power-up or on request. It sits between the local command source (sweep/schedule logic) and the AD9911_LO_*/AD9911_RF_* pins; each DDS gets one instance.

---
 rtl/ad9911_pkg.sv | 46 ++++
 rtl/ad9911_sclk_gen.sv | 51 +++++
 rtl/ad9911_spi_ctrl.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/ad9911_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ad9911_pkg
//  Purpose  : Shared definitions for the AD9911 serial configuration
//             controller: controller state encoding, AD9911 register
//             addresses, the write-instruction bit and a small helper
//             used for sizing counters.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package ad9911_pkg;

    // Controller states. The encoding is explicit so that state values
    // in waveforms stay stable across revisions.
    typedef enum logic [2:0] {
        ST_RST_PULSE = 3'd0,
        ST_RST_WAIT  = 3'd1,
        ST_IDLE      = 3'd2,
        ST_SHIFT     = 3'd3,
        ST_CS_HOLD   = 3'd4,
        ST_UPDATE    = 3'd5,
        ST_FINISH    = 3'd6
    } state_t;

    // AD9911 register addresses.
    localparam logic [4:0] c_ADDR_CSR   = 5'h00;
    localparam logic [4:0] c_ADDR_FR1   = 5'h01;
    localparam logic [4:0] c_ADDR_FR2   = 5'h02;
    localparam logic [4:0] c_ADDR_CFR   = 5'h03;
    localparam logic [4:0] c_ADDR_CTW0  = 5'h04;
    localparam logic [4:0] c_ADDR_CPOW0 = 5'h05;
    localparam logic [4:0] c_ADDR_ACR   = 5'h06;

    // MSB of the instruction byte: 0 selects a register write.
    localparam logic c_WRITE_BIT = 1'b0;

    // Shift word width: one instruction byte plus up to four payload bytes,
    // rounded up to six bytes.
    localparam int c_SHIFT_W = 48;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ad9911_sclk_gen.sv
`default_nettype none
// ============================================================================
//  Module   : ad9911_sclk_gen
//  Purpose  : SCLK phase timer. While enabled it alternates low and high
//             phases of SCLK_DIV clock cycles each, starting with a low
//             phase, and flags the last cycle of each phase. Disabling it
//             returns it to the start of a low phase.
//  Ports    : clk          - system clock
//             rst          - synchronous active-high reset
//             i_en         - run the timer (held high for a whole frame)
//             o_low_last   - last cycle of a low phase
//             o_high_last  - last cycle of a high phase
//  Revision : 1.0 - initial release
// ============================================================================
module ad9911_sclk_gen
    import ad9911_pkg::*;
#(
    parameter int SCLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    output logic o_low_last,
    output logic o_high_last
);

    localparam int                 c_CNT_W    = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(SCLK_DIV - 1);

    logic [c_CNT_W-1:0] r_cnt;
    logic               r_high;
    logic               w_last;

    assign w_last      = i_en && (r_cnt == c_CNT_LAST);
    assign o_low_last  = w_last && !r_high;
    assign o_high_last = w_last &&  r_high;

    always_ff @(posedge clk) begin
        if (rst || !i_en) begin
            r_cnt  <= '0;
            r_high <= 1'b0;
        end else if (r_cnt == c_CNT_LAST) begin
            r_cnt  <= '0;
            r_high <= ~r_high;
        end else begin
            r_cnt  <= r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ad9911_spi_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : ad9911_spi_ctrl
//  Purpose  : Serial configuration controller for one AD9911 DDS. Accepts
//             register writes over a valid/ready handshake, shifts them
//             out MSB first on CS/SCLK/SDIO0, optionally pulses IO_UPDATE
//             afterwards, and runs a master-reset sequence at power-up or
//             on INIT_REQ.
//  Ports    : CLOCK_40M     - sole clock, rising edge
//             RESET_N       - synchronous active-low reset
//             CMD_VALID/CMD_READY - command handshake
//             CMD_ADDR      - register address
//             CMD_DATA      - right-justified payload
//             CMD_LEN       - payload bytes minus one
//             CMD_UPDATE    - pulse IO_UPDATE after the write
//             INIT_REQ      - request a master-reset sequence (level)
//             BUSY          - controller is not idle
//             DONE          - one-cycle completion pulse
//             AD9911_*      - DDS pins (CS, SCLK, SDIO0, UPDATE, MRSET)
//  Revision : 1.0 - initial release
// ============================================================================
module ad9911_spi_ctrl
    import ad9911_pkg::*;
#(
    parameter int SCLK_DIV      = 4,
    parameter int MRSET_CYCLES  = 40,
    parameter int UPDATE_CYCLES = 8
) (
    input  logic        CLOCK_40M,
    input  logic        RESET_N,
    input  logic        CMD_VALID,
    output logic        CMD_READY,
    input  logic [4:0]  CMD_ADDR,
    input  logic [31:0] CMD_DATA,
    input  logic [1:0]  CMD_LEN,
    input  logic        CMD_UPDATE,
    input  logic        INIT_REQ,
    output logic        BUSY,
    output logic        DONE,
    output logic        AD9911_CS,
    output logic        AD9911_SCLK,
    output logic        AD9911_SDIO0,
    output logic        AD9911_UPDATE,
    output logic        AD9911_MRSET
);

    // One delay counter serves the reset pulse, the reset quiet time,
    // the CS hold (SCLK_DIV + 1 cycles) and the IO_UPDATE pulse.
    localparam int c_DLY_MAX = max_int(max_int(MRSET_CYCLES, UPDATE_CYCLES), SCLK_DIV);
    localparam int c_DLY_W   = $clog2(c_DLY_MAX + 1);

    localparam logic [c_DLY_W-1:0] c_MRSET_LAST = c_DLY_W'(MRSET_CYCLES - 1);
    localparam logic [c_DLY_W-1:0] c_HOLD_LAST  = c_DLY_W'(SCLK_DIV);
    localparam logic [c_DLY_W-1:0] c_UPD_LAST   = c_DLY_W'(UPDATE_CYCLES);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   r_run;
    logic [c_DLY_W-1:0]     r_dly;
    logic [c_DLY_W-1:0]     w_dly_nxt;
    logic [c_SHIFT_W-1:0]   r_shift;
    logic [5:0]             r_bit_cnt;
    logic [1:0]             r_len;
    logic                   r_upd;
    logic                   r_sclk;
    logic [5:0]             w_last_bit;
    logic [31:0]            w_payload;
    logic                   w_accept;
    logic                   w_sclk_en;
    logic                   w_low_last;
    logic                   w_high_last;
    logic                   w_rst;

    assign w_rst = ~RESET_N;

    // Payload moved to the top of the 32-bit field so its first byte
    // follows the instruction byte directly: shift by 8*(3-LEN).
    assign w_payload = CMD_DATA << {~CMD_LEN, 3'b000};

    // Index of the final bit of the frame: N-1 = 8*LEN + 15.
    assign w_last_bit = {1'b0, r_len, 3'b000} + 6'd15;

    ad9911_sclk_gen #(
        .SCLK_DIV (SCLK_DIV)
    ) u_sclk_gen (
        .clk         (CLOCK_40M),
        .rst         (w_rst),
        .i_en        (w_sclk_en),
        .o_low_last  (w_low_last),
        .o_high_last (w_high_last)
    );

    // ------------------------------------------------------------------
    // State register. r_run is low only in the cycle right after reset is
    // released... and during reset itself. It masks the pins while RESET_N
    // is low (the state is already RST_PULSE there) and keeps the reset
    // cycle from counting towards the MRSET pulse length.
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK_40M) begin
        if (!RESET_N) begin
            r_state <= ST_RST_PULSE;
            r_dly   <= '0;
            r_run   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_dly   <= w_dly_nxt;
            r_run   <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output decode.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_dly_nxt     = '0;
        w_accept      = 1'b0;
        w_sclk_en     = 1'b0;
        CMD_READY     = 1'b0;
        DONE          = 1'b0;
        BUSY          = r_run && (r_state != ST_IDLE);
        AD9911_CS     = 1'b1;
        AD9911_SCLK   = 1'b0;
        AD9911_SDIO0  = 1'b0;
        AD9911_UPDATE = 1'b0;
        AD9911_MRSET  = 1'b0;

        case (r_state)
            ST_RST_PULSE: begin
                AD9911_MRSET = r_run;
                if (r_run) begin
                    if (r_dly == c_MRSET_LAST) begin
                        w_state_nxt = ST_RST_WAIT;
                    end else begin
                        w_dly_nxt = r_dly + 1'b1;
                    end
                end
            end

            ST_RST_WAIT: begin
                if (r_dly == c_MRSET_LAST) begin
                    w_state_nxt = ST_FINISH;
                end else begin
                    w_dly_nxt = r_dly + 1'b1;
                end
            end

            ST_IDLE: begin
                // A pending init request withdraws READY so that a command
                // presented in the same cycle is visibly not taken.
                CMD_READY = ~INIT_REQ;
                if (INIT_REQ) begin
                    w_state_nxt = ST_RST_PULSE;
                end else if (CMD_VALID) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                w_sclk_en    = 1'b1;
                AD9911_CS    = 1'b0;
                AD9911_SCLK  = r_sclk;
                AD9911_SDIO0 = r_shift[c_SHIFT_W-1];
                if (w_high_last && (r_bit_cnt == w_last_bit)) begin
                    w_state_nxt = ST_CS_HOLD;
                end
            end

            ST_CS_HOLD: begin
                // CS stays low for SCLK_DIV cycles; the final cycle of this
                // state already shows CS high, so DONE or the IO_UPDATE
                // pulse starts one cycle after the CS rise.
                AD9911_CS = (r_dly == c_HOLD_LAST);
                if (r_dly == c_HOLD_LAST) begin
                    w_state_nxt = r_upd ? ST_UPDATE : ST_FINISH;
                end else begin
                    w_dly_nxt = r_dly + 1'b1;
                end
            end

            ST_UPDATE: begin
                // UPDATE_CYCLES high, then one low cycle before DONE.
                AD9911_UPDATE = (r_dly != c_UPD_LAST);
                if (r_dly == c_UPD_LAST) begin
                    w_state_nxt = ST_FINISH;
                end else begin
                    w_dly_nxt = r_dly + 1'b1;
                end
            end

            ST_FINISH: begin
                DONE        = 1'b1;
                w_state_nxt = ST_IDLE;
            end

            default: begin
                w_state_nxt = ST_RST_PULSE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Command latch and shift register. The shift word is loaded
    // left-justified so the frame always starts at the MSB.
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK_40M) begin
        if (!RESET_N) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_len     <= '0;
            r_upd     <= 1'b0;
        end else if (w_accept) begin
            r_shift   <= {c_WRITE_BIT, 2'b00, CMD_ADDR, w_payload, 8'h00};
            r_bit_cnt <= '0;
            r_len     <= CMD_LEN;
            r_upd     <= CMD_UPDATE;
        end else if (w_high_last) begin
            r_shift   <= {r_shift[c_SHIFT_W-2:0], 1'b0};
            r_bit_cnt <= r_bit_cnt + 1'b1;
        end
    end

    // Registered SCLK: rises after each low phase, falls after each high
    // phase, so the pin never glitches between decoded states.
    always_ff @(posedge CLOCK_40M) begin
        if (!RESET_N) begin
            r_sclk <= 1'b0;
        end else if (w_low_last) begin
            r_sclk <= 1'b1;
        end else if (w_high_last) begin
            r_sclk <= 1'b0;
        end
    end

endmodule
`default_nettype wire
